// File: rtl/imem_prog.sv
// Instruction memory with a streaming program loader.
// After reset the array is zero-filled (CLEAR), then instructions can be
// fetched with one cycle of latency (READY). A program is streamed in with a
// valid/ready handshake starting at word 0 (LOAD); the unwritten tail is
// zero-filled afterwards so no stale program words survive a shorter reload.
module imem_prog #(
  parameter int N      = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              fetch_req,
  output logic [N-1:0]      q,
  output logic              q_valid,
  input  logic              load_start,
  input  logic [N-1:0]      load_data,
  input  logic              load_valid,
  input  logic              load_last,
  output logic              load_ready,
  output logic              busy,
  output logic              load_err,
  output logic [ADDR_W:0]   load_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_READY = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   clr_ptr_reg, clr_ptr_next;
  logic [ADDR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W:0]     load_count_reg, load_count_next;
  logic                load_err_reg, load_err_next;
  logic [N-1:0]        q_reg;
  logic                q_valid_reg;

  // Single write port shared by the zero-fill and the loader.
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [N-1:0]        mem_wdata;
  logic [N-1:0]        mem [DEPTH];

  logic accept;
  assign accept = (state_reg == ST_LOAD) && load_valid;

  // Next-state, pointer/counter updates and memory write selection.
  always_comb begin
    state_next      = state_reg;
    clr_ptr_next    = clr_ptr_reg;
    wr_ptr_next     = wr_ptr_reg;
    load_count_next = load_count_reg;
    load_err_next   = load_err_reg;
    mem_we          = 1'b0;
    mem_waddr       = clr_ptr_reg;
    mem_wdata       = '0;
    case (state_reg)
      ST_CLEAR: begin
        mem_we       = 1'b1;
        clr_ptr_next = clr_ptr_reg + 1'b1;
        if (clr_ptr_reg == LAST_ADDR) state_next = ST_READY;
      end
      ST_READY: begin
        if (load_start) begin
          state_next      = ST_LOAD;
          wr_ptr_next     = '0;
          load_count_next = '0;
          load_err_next   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          mem_we          = 1'b1;
          mem_waddr       = wr_ptr_reg;
          mem_wdata       = load_data;
          wr_ptr_next     = wr_ptr_reg + 1'b1;
          load_count_next = load_count_reg + 1'b1;
          if (load_last) begin
            if (wr_ptr_reg != LAST_ADDR) begin
              // Zero the words this shorter program did not overwrite.
              state_next   = ST_CLEAR;
              clr_ptr_next = wr_ptr_reg + 1'b1;
            end else begin
              state_next = ST_READY;
            end
          end else if (wr_ptr_reg == LAST_ADDR) begin
            // Array full and more words still coming: flag, never wrap.
            load_err_next = 1'b1;
            state_next    = ST_READY;
          end
        end
      end
      default: state_next = ST_CLEAR;
    endcase
    if (reset) mem_we = 1'b0;
  end

  // Control state registers; reset restarts the zero-fill from word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_CLEAR;
      clr_ptr_reg    <= '0;
      wr_ptr_reg     <= '0;
      load_count_reg <= '0;
      load_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      clr_ptr_reg    <= clr_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      load_count_reg <= load_count_next;
      load_err_reg   <= load_err_next;
    end
  end

  // Memory array write port (no reset so it maps onto block RAM).
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Registered fetch port; only served in READY, q holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg       <= '0;
      q_valid_reg <= 1'b0;
    end else begin
      q_valid_reg <= 1'b0;
      if (state_reg == ST_READY && fetch_req) begin
        q_reg       <= mem[addr];
        q_valid_reg <= 1'b1;
      end
    end
  end

  assign q          = q_reg;
  assign q_valid    = q_valid_reg;
  assign load_ready = (state_reg == ST_LOAD);
  assign busy       = (state_reg != ST_READY);
  assign load_err   = load_err_reg;
  assign load_count = load_count_reg;

endmodule
